tx_arbiter: RTL and testbench

//  Shares the single sendController byte channel between two requesters: the random-byte stream
//  (sampleToTransmitPerf) and a status-frame source (matched/noFound/ROSel/CSCnt snapshot).

---
 rtl/coso_tx_pkg.sv | 27 ++
 rtl/status_serializer.sv | 68 ++++++
 rtl/tx_arbiter.sv | 110 +++++++++++
 tb/tb_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coso_tx_pkg.sv
// Shared types and helpers for the transmit arbiter.
// Optional build macro TX_ARB_CHECKSUM_EN appends an XOR checksum byte to status frames.
package coso_tx_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // Arbiter state encoding; ST_HDR is reserved, the header goes out directly from IDLE
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ST_HDR    = 3'd1,
        ST_BODY   = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } arb_state_t;

`ifdef TX_ARB_CHECKSUM_EN
    localparam int unsigned CHK_BYTES = 1;
`else
    localparam int unsigned CHK_BYTES = 0;
`endif

    // Total bytes on the wire for one status frame, header included
    function automatic int unsigned frame_len(input int unsigned status_bytes);
        return status_bytes + 1 + CHK_BYTES;
    endfunction

endpackage

// File: rtl/status_serializer.sv
// Status frame body source: shadow of the payload, byte index and byte mux.
// With TX_ARB_CHECKSUM_EN the body ends with an XOR of header and payload bytes.
module status_serializer
    import coso_tx_pkg::*;
#(
    parameter int unsigned STATUS_BYTES = 4,
    parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      advance,
    input  logic [8*STATUS_BYTES-1:0] st_word,
    output logic [7:0]                cur_byte_c,
    output logic                      last_c
);

    // Body bytes follow the header: payload plus optional checksum
    localparam int unsigned BODY_LEN = frame_len(STATUS_BYTES) - 1;
    localparam int unsigned IDX_W    = 4;

    logic [8*STATUS_BYTES-1:0] shadow;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                pay;

    // Capture payload at frame start; step the index after each body byte except the last
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            idx    <= '0;
        end else if (load) begin
            shadow <= st_word;
            idx    <= '0;
        end else if (advance && !last_c) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Payload byte select; indices past the payload read as zero
    always_comb begin
        pay = '0;
        for (int unsigned i = 0; i < STATUS_BYTES; i++) begin
            if (idx == IDX_W'(i)) pay = shadow[8*i +: 8];
        end
    end

`ifdef TX_ARB_CHECKSUM_EN
    logic [7:0] acc;

    // Running XOR seeded with the header so the final value covers the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= HDR_BYTE;
        end else if (advance) begin
            acc <= acc ^ pay;
        end
    end

    assign cur_byte_c = (idx == IDX_W'(STATUS_BYTES)) ? acc : pay;
`else
    assign cur_byte_c = pay;
`endif

    assign last_c = (idx == IDX_W'(BODY_LEN - 1));

endmodule

// File: rtl/tx_arbiter.sv
// Shares the sender byte channel between the random-byte stream and atomic status frames,
// bounding random-data starvation of a pending status frame to RND_BURST bytes.
// Optional build macro TX_ARB_CHECKSUM_EN adds a trailing checksum byte per status frame.
module tx_arbiter
    import coso_tx_pkg::*;
#(
    parameter int unsigned STATUS_BYTES = 4,
    parameter int unsigned RND_BURST    = 16,
    parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rnd_valid,
    input  logic [7:0]                rnd_byte,
    output logic                      rnd_ready,
    input  logic                      st_req,
    input  logic [8*STATUS_BYTES-1:0] st_word,
    output logic                      st_ack,
    input  logic                      is_transmitting,
    output logic                      transmit,
    output logic [7:0]                tx_byte
);

    localparam int unsigned BURST_W = $clog2(RND_BURST + 1);

    arb_state_t         state;
    arb_state_t         ret_state;
    logic [BURST_W-1:0] burst_cnt;

    logic       burst_full_c;
    logic       hdr_sel_c;
    logic       ser_advance_c;
    logic [7:0] ser_byte_c;
    logic       ser_last_c;

    assign burst_full_c  = (burst_cnt == BURST_W'(RND_BURST));
    assign hdr_sel_c     = (state == IDLE) && !is_transmitting && st_req
                           && (!rnd_valid || burst_full_c);
    assign ser_advance_c = (state == ST_BODY) && !is_transmitting;

    status_serializer #(
        .STATUS_BYTES (STATUS_BYTES),
        .HDR_BYTE     (HDR_BYTE)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (hdr_sel_c),
        .advance    (ser_advance_c),
        .st_word    (st_word),
        .cur_byte_c (ser_byte_c),
        .last_c     (ser_last_c)
    );

    // Arbiter FSM, burst counter and registered sender handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            burst_cnt <= '0;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            rnd_ready <= 1'b0;
            st_ack    <= 1'b0;
        end else begin
            transmit  <= 1'b0;
            rnd_ready <= 1'b0;
            st_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_sel_c) begin
                        transmit  <= 1'b1;
                        tx_byte   <= HDR_BYTE;
                        ret_state <= ST_BODY;
                        state     <= WAIT_BUSY;
                    end else if (rnd_valid && !is_transmitting) begin
                        transmit  <= 1'b1;
                        tx_byte   <= rnd_byte;
                        rnd_ready <= 1'b1;
                        ret_state <= IDLE;
                        state     <= WAIT_BUSY;
                        if (st_req && !burst_full_c) begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end
                end
                ST_BODY: begin
                    if (!is_transmitting) begin
                        transmit <= 1'b1;
                        tx_byte  <= ser_byte_c;
                        state    <= WAIT_BUSY;
                        if (ser_last_c) begin
                            st_ack    <= 1'b1;
                            burst_cnt <= '0;
                            ret_state <= IDLE;
                        end else begin
                            ret_state <= ST_BODY;
                        end
                    end
                end
                // Sender may not have raised busy yet; skip one cycle
                WAIT_BUSY: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (!is_transmitting) state <= ret_state;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter (honours TX_ARB_CHECKSUM_EN when defined).
module tb_tx_arbiter;

    localparam int unsigned STATUS_BYTES = 4;
    localparam int unsigned RND_BURST    = 16;
    localparam logic [7:0]  HDR          = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rnd_valid;
    logic [7:0]  rnd_byte;
    logic        rnd_ready;
    logic        st_req;
    logic [31:0] st_word;
    logic        st_ack;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;

    always #5 clk = ~clk;

    tx_arbiter #(
        .STATUS_BYTES (STATUS_BYTES),
        .RND_BURST    (RND_BURST),
        .HDR_BYTE     (HDR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rnd_valid       (rnd_valid),
        .rnd_byte        (rnd_byte),
        .rnd_ready       (rnd_ready),
        .st_req          (st_req),
        .st_word         (st_word),
        .st_ack          (st_ack),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       rr;
        logic       ack;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  chk;
    } st_vec_t;

    exp_t    exp_q[$];
    st_vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tx = -10;
    int tx_seen = 0;
    int ack_seen = 0;
    int busy_cnt = 0;
    int busy_len = 4;
    int rnd_left = 0;
    logic [7:0] rnd_next = 8'h00;
    logic stuck = 1'b0;
    logic st_drop = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One cycle: monitor/scoreboard, sender model, random source, status source
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (transmit) begin
            checks++;
            if (cyc - last_tx < 2) begin
                errors++;
                $display("FAIL tx_gap act=%0d exp>=2", cyc - last_tx);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx act=%02h/rr%0b/ack%0b exp=none", tx_byte, rnd_ready, st_ack);
            end else begin
                e = exp_q.pop_front();
                if ({tx_byte, rnd_ready, st_ack} !== e) begin
                    errors++;
                    $display("FAIL tx_byte act=%02h/rr%0b/ack%0b exp=%02h/rr%0b/ack%0b",
                             tx_byte, rnd_ready, st_ack, e.b, e.rr, e.ack);
                end
            end
            last_tx = cyc;
            tx_seen++;
            if (st_ack) ack_seen++;
        end else begin
            checks++;
            if (rnd_ready || st_ack) begin
                errors++;
                $display("FAIL stray_pulse act=rr%0b/ack%0b exp=0/0", rnd_ready, st_ack);
            end
        end
        if (transmit) busy_cnt = busy_len;
        else if (busy_cnt != 0) busy_cnt--;
        is_transmitting = stuck || (busy_cnt != 0);
        if (rnd_ready && rnd_left != 0) begin
            rnd_left--;
            rnd_next = rnd_next + 8'd1;
        end
        rnd_valid = (rnd_left != 0);
        rnd_byte  = rnd_next;
        if (st_ack && st_drop) st_req = 1'b0;
    endtask

    task automatic rnd_start(input int n, input logic [7:0] first);
        rnd_left  = n;
        rnd_next  = first;
        rnd_valid = (n != 0);
        rnd_byte  = first;
    endtask

    task automatic push_rnd(input logic [7:0] first, input int n);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{b: b, rr: 1'b1, ack: 1'b0});
            b = b + 8'd1;
        end
    endtask

    task automatic push_frame(input st_vec_t v);
        logic [7:0] b;
        exp_q.push_back('{b: HDR, rr: 1'b0, ack: 1'b0});
        for (int i = 0; i < 4; i++) begin
            b = v.word[8*i +: 8];
`ifdef TX_ARB_CHECKSUM_EN
            exp_q.push_back('{b: b, rr: 1'b0, ack: 1'b0});
`else
            exp_q.push_back('{b: b, rr: 1'b0, ack: (i == 3)});
`endif
        end
`ifdef TX_ARB_CHECKSUM_EN
        exp_q.push_back('{b: v.chk, rr: 1'b0, ack: 1'b1});
`endif
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout act_left=%0d exp_left=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (12) step();
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_seen < target && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        int base;
        int ack_base;
        logic [7:0] hold;
        logic stable;

        vecs[0] = '{word: 32'h44332211, chk: 8'hE1};
        vecs[1] = '{word: 32'h00000000, chk: 8'hA5};
        vecs[2] = '{word: 32'hFFFFFFFF, chk: 8'hA5};
        vecs[3] = '{word: 32'h01020304, chk: 8'hA1};
        vecs[4] = '{word: 32'h5A5A5A5A, chk: 8'hA5};

        rst = 1'b1;
        rnd_valid = 1'b0;
        rnd_byte = 8'h00;
        st_req = 1'b0;
        st_word = 32'h0;
        is_transmitting = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_transmit", 32'(transmit), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        chk("rst_st_ack", 32'(st_ack), 32'd0);
        rst = 1'b0;
        step();

        // 1: random stream only
        push_rnd(8'h01, 5);
        rnd_start(5, 8'h01);
        drain("rnd_only");

        // 2: status frames from the vector table
        for (int i = 0; i < 5; i++) begin
            ack_base = ack_seen;
            st_word = vecs[i].word;
            st_req = 1'b1;
            push_frame(vecs[i]);
            drain("status");
            chk("status_ack_count", 32'(ack_seen - ack_base), 32'd1);
            chk("status_req_dropped", 32'(st_req), 32'd0);
        end

        // 4: payload and request change after the header
        ack_base = ack_seen;
        st_word = vecs[0].word;
        st_req = 1'b1;
        push_frame(vecs[0]);
        base = tx_seen;
        wait_tx(base + 1);
        st_word = 32'hDEADBEEF;
        st_req = 1'b0;
        drain("shadow");
        chk("shadow_ack_count", 32'(ack_seen - ack_base), 32'd1);

        // 5: reset after the second payload byte, then restart
        ack_base = ack_seen;
        st_word = 32'h87654321;
        st_req = 1'b1;
        push_frame('{word: 32'h87654321, chk: 8'hA5 ^ 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87});
        base = tx_seen;
        wait_tx(base + 3);
        rst = 1'b1;
        step();
        chk("midrst_transmit", 32'(transmit), 32'd0);
        chk("midrst_st_ack", 32'(st_ack), 32'd0);
        chk("midrst_rnd_ready", 32'(rnd_ready), 32'd0);
        chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        push_frame('{word: 32'h87654321, chk: 8'hA5 ^ 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87});
        drain("restart");
        chk("restart_ack_count", 32'(ack_seen - ack_base), 32'd1);

        // 3: contention, twice to show the burst count clears after each frame
        for (int k = 0; k < 2; k++) begin
            logic [7:0] first;
            first = (k == 0) ? 8'h10 : 8'h40;
            ack_base = ack_seen;
            push_rnd(first, RND_BURST);
            push_frame(vecs[3 + k]);
            push_rnd(first + 8'(RND_BURST), 8);
            st_word = vecs[3 + k].word;
            st_req = 1'b1;
            rnd_start(RND_BURST + 8, first);
            drain("contention");
            chk("contention_ack_count", 32'(ack_seen - ack_base), 32'd1);
        end

        // 6: sender stuck busy
        stuck = 1'b1;
        is_transmitting = 1'b1;
        rnd_start(3, 8'h60);
        base = tx_seen;
        hold = tx_byte;
        stable = 1'b1;
        repeat (100) begin
            step();
            if (tx_byte !== hold) stable = 1'b0;
        end
        chk("stuck_tx_count", 32'(tx_seen - base), 32'd0);
        chk("stuck_tx_byte_stable", 32'(stable), 32'd1);
        chk("stuck_rnd_pending", 32'(rnd_left), 32'd3);
        stuck = 1'b0;
        push_rnd(8'h60, 3);
        drain("unstuck");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
